// File: rtl/z16_regfile_write_arbiter.sv
// Write-port arbiter for the Z16 register file: a post-reset init sweep, then
// round-robin sharing of the rd write port between ALU (A) and load (B) writebacks.
module z16_regfile_write_arbiter #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 4,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_valid,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_ready,
  output logic              o_rd_wen,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_init_busy
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              last_b;
  logic              grant_a, grant_b;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= INIT;
    else       state <= state_next;
  end

  // On a conflict the source that did not win last time is granted.
  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    case (state)
      INIT: if (sweep_cnt == '1) state_next = RUN;
      RUN: begin
        if (i_a_valid && (!i_b_valid || last_b)) grant_a = 1'b1;
        else if (i_b_valid)                      grant_b = 1'b1;
      end
      default: state_next = INIT;
    endcase
  end

  assign o_a_ready   = grant_a;
  assign o_b_ready   = grant_b;
  assign o_init_busy = (state == INIT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sweep_cnt <= '0;
      last_b    <= 1'b1;
      o_rd_wen  <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else if (state == INIT) begin
      o_rd_wen  <= 1'b1;
      o_rd_addr <= sweep_cnt;
      o_rd_data <= INIT_VALUE;
      sweep_cnt <= sweep_cnt + 1'b1;
    end else if (grant_a) begin
      o_rd_wen  <= 1'b1;
      o_rd_addr <= i_a_addr;
      o_rd_data <= i_a_data;
      last_b    <= 1'b0;
    end else if (grant_b) begin
      o_rd_wen  <= 1'b1;
      o_rd_addr <= i_b_addr;
      o_rd_data <= i_b_data;
      last_b    <= 1'b1;
    end else begin
      // Address and data hold so an idle port does not toggle.
      o_rd_wen  <= 1'b0;
    end
  end

endmodule
